fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF-stage front end of the 5-stage MIPS pipeline. Owns the program counter and the IF/ID pipeline register.
- Drives the fetch address into the combinational instruction memory and captures the returned word into IF/ID.
- Obeys stall from the hazard detection unit, and flush/redirect from branch resolution in ID.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
- IMEM_WORDS, 64, instruction memory depth in words; fetch range is [0, 4*IMEM_WORDS).
- NOP_WORD, 32'h0000_0000, word inserted into IF/ID on flush, bubble or halt.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- instr_i  in  32  word returned by instruction memory for pc_o (same cycle, combinational)
- stall_i  in  1  hazard unit: hold PC and IF/ID
- flush_i  in  1  squash the word being fetched this cycle
- redirect_i  in  1  load PC from redirect_pc_i
- redirect_pc_i  in  32  branch/jump target, byte address
- pc_o  out  32  current fetch address to instruction memory
- ifid_instr_o  out  32  IF/ID instruction
- ifid_pc4_o  out  32  IF/ID PC+4 of the captured instruction
- ifid_valid_o  out  1  IF/ID holds a real fetched instruction
- halted_o  out  1  fetch ran past end of memory

Behaviour:
- Reset rst: asynchronous, active-high.
- While rst is high:
  - pc_o=RESET_PC, ifid_instr_o=NOP_WORD, ifid_pc4_o=0, ifid_valid_o=0, halted_o=0.
  - FSM=BOOT.
- FSM states:
  - BOOT: exactly one cycle after rst falls. Gives the memory preload time. PC holds and IF/ID holds NOP/valid=0. Next state is RUN.
  - RUN: normal fetch.
  - END: entered on the edge where next PC >= 4*IMEM_WORDS and no redirect. In END:
    - PC holds.
    - IF/ID loads NOP_WORD with valid=0 every unstalled cycle.
    - halted_o=1.
    - A redirect to an in-range address returns to RUN (halted_o=0 the next cycle).
    - A redirect to an out-of-range address stays in END.
- Per-edge priority in RUN (highest first):
  1. redirect_i: PC <= {redirect_pc_i[31:2],2'b00}; IF/ID <= NOP_WORD, valid=0. This wins over stall_i and flush_i.
  2. flush_i without redirect: PC <= PC+4; IF/ID <= NOP_WORD, valid=0.
  3. stall_i: PC and IF/ID unchanged.
  4. Otherwise: PC <= PC+4; IF/ID <= {instr_i, PC+4}, valid=1.
- redirect_i during BOOT is ignored. stall_i during END holds IF/ID.
- Latency: the instruction at address A appears on ifid_instr_o one edge after pc_o==A with no stall.
- The first instruction after reset is visible at the second rising edge after rst falls.
- Arithmetic:
  - PC+4 is 32-bit modulo; wrap past 32'hFFFF_FFFC gives 0, which is in range, so the FSM stays in RUN.
  - The range check uses the unsigned compare PC+4 >= 4*IMEM_WORDS.
- Unaligned redirect targets are force-aligned; there is no exception.
- Reset mid-operation: all state clears immediately, and no partial IF/ID update occurs.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds these outputs, all cleared by rst and saturating at all-ones:
  - fetch_cnt_o [31:0]: increments on each edge that loads IF/ID with valid=1.
  - stall_cnt_o [15:0]: increments on each edge with stall_i in RUN.
  - flush_cnt_o [15:0]: increments on each edge with redirect_i or flush_i applied.
- When undefined: the ports and counters do not exist, and functional behaviour is identical.

Test Plan:
- Reset/boot: assert rst, release, memory word0=32'h2010_0030 -> pc_o=0 for 2 cycles, then ifid_instr_o=32'h2010_0030, ifid_pc4_o=4, valid=1, pc_o=8 one cycle later.
- Stall: in RUN at pc_o=0x18, hold stall_i 3 cycles -> pc_o stays 0x18 and IF/ID unchanged for 3 cycles; resumes at 0x1C; stall_cnt_o=3 with FETCH_PERF_CNT_EN.
- Redirect over stall: at pc_o=0x2C assert redirect_i with target 0x6B and stall_i in the same cycle -> pc_o=0x68 next, IF/ID=NOP, valid=0.
- Flush alone: flush_i at pc_o=0x30 -> pc_o=0x34, ifid_valid_o=0, ifid_instr_o=0.
- End of memory: run from 0 without branches, IMEM_WORDS=64 -> after the word at 0xFC is captured, halted_o=1, pc_o=0x100 held, valid=0; redirect to 0x10 -> halted_o=0, fetch resumes at 0x10.
- Async reset mid-run: rst pulse between clock edges at pc_o=0x40 -> outputs reset immediately, without waiting for a clock edge; BOOT then RUN from 0.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : IF stage of the 5-stage MIPS pipeline. Owns the program
//                counter and the IF/ID pipeline register. Drives the fetch
//                address to a combinational instruction memory and captures
//                the returned word. Honours stall from the hazard unit and
//                flush/redirect from branch resolution in ID.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   rising-edge clock
//    rst            in   asynchronous active-high reset
//    instr_i        in   [31:0] imem word for pc_o (same cycle)
//    stall_i        in   hold PC and IF/ID
//    flush_i        in   squash the word fetched this cycle
//    redirect_i     in   load PC from redirect_pc_i
//    redirect_pc_i  in   [31:0] branch/jump target (byte address)
//    pc_o           out  [31:0] current fetch address
//    ifid_instr_o   out  [31:0] IF/ID instruction
//    ifid_pc4_o     out  [31:0] IF/ID PC+4 of the captured instruction
//    ifid_valid_o   out  IF/ID holds a real fetched instruction
//    halted_o       out  fetch ran past end of memory
//  Optional (macro FETCH_PERF_CNT_EN)
//    fetch_cnt_o    out  [31:0] valid IF/ID loads (saturating)
//    stall_cnt_o    out  [15:0] stalled edges in RUN (saturating)
//    flush_cnt_o    out  [15:0] applied redirects/flushes (saturating)
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] instr_i,
    input  wire logic        stall_i,
    input  wire logic        flush_i,
    input  wire logic        redirect_i,
    input  wire logic [31:0] redirect_pc_i,
    output logic      [31:0] pc_o,
    output logic      [31:0] ifid_instr_o,
    output logic      [31:0] ifid_pc4_o,
    output logic             ifid_valid_o,
    output logic             halted_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic      [31:0] fetch_cnt_o,
    output logic      [15:0] stall_cnt_o,
    output logic      [15:0] flush_cnt_o
`endif
);

    // 33 bits so the limit itself never wraps for large memories.
    localparam logic [32:0] c_pc_limit = 33'(IMEM_WORDS) << 2;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_END  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_ifid_instr_nxt;
    logic [31:0] w_ifid_pc4_nxt;
    logic        w_ifid_valid_nxt;
    logic [31:0] w_pc_inc;
    logic [31:0] w_redir_pc;
    logic        w_inc_oob;
    logic        w_redir_oob;
    logic        w_load_valid;
    logic        w_stall_evt;
    logic        w_flush_evt;
    logic        w_unused_bits;

    // Low target bits are discarded by force-alignment.
    assign w_unused_bits = &{1'b0, redirect_pc_i[1:0]};

    assign w_pc_inc    = r_pc + 32'd4;
    assign w_redir_pc  = {redirect_pc_i[31:2], 2'b00};
    assign w_inc_oob   = ({1'b0, w_pc_inc}   >= c_pc_limit);
    assign w_redir_oob = ({1'b0, w_redir_pc} >= c_pc_limit);

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc4_nxt   = r_ifid_pc4;
        w_ifid_valid_nxt = r_ifid_valid;
        w_load_valid     = 1'b0;
        w_stall_evt      = 1'b0;
        w_flush_evt      = 1'b0;
        case (r_state)
            // One idle cycle for memory preload; redirect is ignored here.
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                w_stall_evt = stall_i;
                if (redirect_i) begin
                    w_pc_nxt         = w_redir_pc;
                    w_ifid_instr_nxt = NOP_WORD;
                    w_ifid_pc4_nxt   = 32'd0;
                    w_ifid_valid_nxt = 1'b0;
                    w_flush_evt      = 1'b1;
                end else if (flush_i) begin
                    w_pc_nxt         = w_pc_inc;
                    w_ifid_instr_nxt = NOP_WORD;
                    w_ifid_pc4_nxt   = 32'd0;
                    w_ifid_valid_nxt = 1'b0;
                    w_flush_evt      = 1'b1;
                    if (w_inc_oob) w_state_nxt = ST_END;
                end else if (!stall_i) begin
                    w_pc_nxt         = w_pc_inc;
                    w_ifid_instr_nxt = instr_i;
                    w_ifid_pc4_nxt   = w_pc_inc;
                    w_ifid_valid_nxt = 1'b1;
                    w_load_valid     = 1'b1;
                    if (w_inc_oob) w_state_nxt = ST_END;
                end
            end
            ST_END: begin
                if (redirect_i) begin
                    w_pc_nxt         = w_redir_pc;
                    w_ifid_instr_nxt = NOP_WORD;
                    w_ifid_pc4_nxt   = 32'd0;
                    w_ifid_valid_nxt = 1'b0;
                    w_flush_evt      = 1'b1;
                    w_state_nxt      = w_redir_oob ? ST_END : ST_RUN;
                end else if (!stall_i) begin
                    w_ifid_instr_nxt = NOP_WORD;
                    w_ifid_pc4_nxt   = 32'd0;
                    w_ifid_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_ifid_instr <= NOP_WORD;
            r_ifid_pc4   <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc4   <= w_ifid_pc4_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
        end
    end

    assign pc_o         = r_pc;
    assign ifid_instr_o = r_ifid_instr;
    assign ifid_pc4_o   = r_ifid_pc4;
    assign ifid_valid_o = r_ifid_valid;
    assign halted_o     = (r_state == ST_END);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_load_valid && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_stall_evt  && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_flush_evt  && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    logic w_unused_evt;
    assign w_unused_evt = &{1'b0, w_load_valid, w_stall_evt, w_flush_evt};
`endif

endmodule
`default_nettype wire
